// File: rtl/sa_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: loads weights, clears,
// streams M activation vectors, drains the skewed pipeline and flags result rows.
module sa_ctrl #(
    parameter int N  = 4,
    parameter int CW = 8,
    parameter int L  = 3*N-1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [CW-1:0]                     num_rows,
    input  logic                              abort,
    input  logic                              act_avail,
    output logic                              weight_load,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] w_row,
    output logic                              clear,
    output logic                              en,
    output logic                              act_rd,
    output logic [CW-1:0]                     act_row,
    output logic                              res_valid,
    output logic [CW-1:0]                     res_row,
    output logic                              busy,
    output logic                              done
);

    localparam int WW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = $clog2(L + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   m_q;
    logic [CW-1:0]   m_last;
    logic [DW-1:0]   drain_cnt;
    logic [L-1:0]    vld_p;

    assign m_last = m_q - CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_W;
            LOAD_W:  if (w_row == WW'(N-1)) state_nxt = CLEAR;
            CLEAR:   state_nxt = (m_q == '0) ? DONE : STREAM;
            STREAM:  if (act_avail && act_row == m_last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DW'(L-1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    // Outputs decode registered state; only the STREAM handshake follows act_avail.
    assign weight_load = (state == LOAD_W);
    assign clear       = (state == CLEAR);
    assign act_rd      = (state == STREAM) && act_avail;
    assign en          = (state == LOAD_W) || (state == CLEAR) || (state == DRAIN) ||
                         (state == DONE)   || act_rd;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    // Gated by en so a frozen pipeline cannot repeat a result flag.
    assign res_valid   = vld_p[L-1] && en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            w_row     <= '0;
            act_row   <= '0;
            res_row   <= '0;
            drain_cnt <= '0;
            vld_p     <= '0;
        end else if (state == IDLE && start) begin
            m_q       <= num_rows;
            w_row     <= '0;
            act_row   <= '0;
            res_row   <= '0;
            drain_cnt <= '0;
            vld_p     <= '0;
        end else if (abort && state != IDLE) begin
            w_row     <= '0;
            act_row   <= '0;
            res_row   <= '0;
            drain_cnt <= '0;
            vld_p     <= '0;
        end else begin
            if (weight_load)
                w_row <= (w_row == WW'(N-1)) ? '0 : w_row + WW'(1);
            // Row indices saturate at M-1 so the maximum count never wraps.
            if (act_rd && act_row != m_last)
                act_row <= act_row + CW'(1);
            if (res_valid && res_row != m_last)
                res_row <= res_row + CW'(1);
            if (state == DRAIN)
                drain_cnt <= drain_cnt + DW'(1);
            if (en) begin
                for (int i = L-1; i > 0; i--) vld_p[i] <= vld_p[i-1];
                vld_p[0] <= act_rd;
            end
        end
    end

endmodule

// File: tb/tb_sa_ctrl.sv
// Scoreboard bench for sa_ctrl: stimulus pushes expected (cycle, event, index)
// records; a negedge monitor pops and compares every event the DUT shows.
module tb_sa_ctrl;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int L  = 3*N-1;

    localparam int K_WL = 0, K_CLR = 1, K_RD = 2, K_RV = 3, K_DONE = 4, K_STALL = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_rows = '0;
    logic          abort = 1'b0;
    logic          act_avail = 1'b0;
    logic          weight_load, clear, en, act_rd, res_valid, busy, done;
    logic [1:0]    w_row;
    logic [CW-1:0] act_row, res_row;

    sa_ctrl #(.N(N), .CW(CW), .L(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .abort(abort),
        .act_avail(act_avail), .weight_load(weight_load), .w_row(w_row), .clear(clear),
        .en(en), .act_rd(act_rd), .act_row(act_row), .res_valid(res_valid),
        .res_row(res_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;
        int idx;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  avail_pat[0:4095];
    int  rdt[0:255];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_ev(input int c, input int kind, input int idx);
        ev_t e;
        int  pos;
        e.cyc = c; e.kind = kind; e.idx = idx;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc * 8 + q[i].kind > c * 8 + kind) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, e);
    endfunction

    task automatic observe(input int kind, input int idx);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event kind=%0d got cyc=%0d idx=%0d, required none", kind, cyc, idx);
        end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.kind != kind || e.idx != idx) begin
                n_bad++;
                $display("FAIL event got kind=%0d cyc=%0d idx=%0d, required kind=%0d cyc=%0d idx=%0d",
                         kind, cyc, idx, e.kind, e.cyc, e.idx);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (weight_load)  observe(K_WL, int'(w_row));
            if (clear)        observe(K_CLR, 0);
            if (act_rd)       observe(K_RD, int'(act_row));
            if (res_valid)    observe(K_RV, int'(res_row));
            if (done)         observe(K_DONE, 0);
            if (busy && !en)  observe(K_STALL, 0);
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({weight_load, w_row, clear, en, act_rd, act_row,
                          res_valid, res_row, busy, done}), 0);
    endtask

    task automatic fill_avail();
        for (int i = 0; i < 4096; i++) avail_pat[i] = 1'b1;
    endtask

    task automatic run_op(input int m, input int abort_at, input int extra_start, input int ncyc);
        for (int rel = 0; rel < ncyc; rel++) begin
            start     = (rel == 0) || (rel == extra_start);
            num_rows  = (rel == 0) ? CW'(m) : CW'(7);
            abort     = (rel == abort_at);
            act_avail = avail_pat[rel];
            if (abort_at >= 0 && rel == abort_at + 1)
                check("busy_after_abort", int'(busy), (abort_at == 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic expect_front(input int b);
        for (int i = 1; i <= 4; i++) expect_ev(b + i, K_WL, i - 1);
        expect_ev(b + 5, K_CLR, 0);
    endtask

    initial begin
        int b, t, k, c, cnt, send;
        fill_avail();

        // Reset state
        #12;
        check_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");

        // M=3, continuous activations
        b = cyc;
        expect_front(b);
        for (int i = 0; i < 3; i++) expect_ev(b + 6 + i, K_RD, i);
        for (int i = 0; i < 3; i++) expect_ev(b + 17 + i, K_RV, i);
        expect_ev(b + 20, K_DONE, 0);
        run_op(3, -1, -1, 23);

        // M=3, feeder empty in relative cycle 7
        fill_avail();
        avail_pat[7] = 1'b0;
        b = cyc;
        expect_front(b);
        expect_ev(b + 6, K_RD, 0);
        expect_ev(b + 7, K_STALL, 0);
        expect_ev(b + 8, K_RD, 1);
        expect_ev(b + 9, K_RD, 2);
        for (int i = 0; i < 3; i++) expect_ev(b + 18 + i, K_RV, i);
        expect_ev(b + 21, K_DONE, 0);
        run_op(3, -1, -1, 24);
        fill_avail();

        // M=0 skips streaming
        b = cyc;
        expect_front(b);
        expect_ev(b + 6, K_DONE, 0);
        run_op(0, -1, -1, 9);

        // Abort in DRAIN, then a fresh start 15 cycles after the first
        b = cyc;
        expect_front(b);
        for (int i = 0; i < 3; i++) expect_ev(b + 6 + i, K_RD, i);
        run_op(3, 12, -1, 15);
        b = cyc;
        expect_front(b);
        for (int i = 0; i < 3; i++) expect_ev(b + 6 + i, K_RD, i);
        for (int i = 0; i < 3; i++) expect_ev(b + 17 + i, K_RV, i);
        expect_ev(b + 20, K_DONE, 0);
        run_op(3, -1, -1, 23);

        // Reset asserted during DRAIN
        b = cyc;
        expect_front(b);
        for (int i = 0; i < 3; i++) expect_ev(b + 6 + i, K_RD, i);
        run_op(3, -1, -1, 12);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_in_drain");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // M=1 with a second start (num_rows=7) while busy
        b = cyc;
        expect_front(b);
        expect_ev(b + 6, K_RD, 0);
        expect_ev(b + 17, K_RV, 0);
        expect_ev(b + 18, K_DONE, 0);
        run_op(1, -1, 3, 21);

        // M=2 with abort coinciding with start in IDLE
        b = cyc;
        expect_front(b);
        expect_ev(b + 6, K_RD, 0);
        expect_ev(b + 7, K_RD, 1);
        expect_ev(b + 17, K_RV, 0);
        expect_ev(b + 18, K_RV, 1);
        expect_ev(b + 19, K_DONE, 0);
        run_op(2, 0, -1, 22);

        // M=255 with random feeder availability
        for (int i = 0; i < 4096; i++) avail_pat[i] = ($urandom_range(0, 3) != 0);
        b = cyc;
        expect_front(b);
        t = 6;
        k = 0;
        while (k < 255 && t < 4000) begin
            if (avail_pat[t]) begin
                expect_ev(b + t, K_RD, k);
                rdt[k] = t;
                k++;
            end else begin
                expect_ev(b + t, K_STALL, 0);
            end
            t++;
        end
        send = t;
        for (int i = 0; i < 255; i++) begin
            c = rdt[i];
            cnt = 0;
            while (cnt < L) begin
                c++;
                if (c >= send || avail_pat[c]) cnt++;
            end
            expect_ev(b + c, K_RV, i);
        end
        expect_ev(b + send + L, K_DONE, 0);
        run_op(255, -1, -1, send + L + 3);
        fill_avail();

        repeat (3) @(posedge clk);
        #1;
        check("leftover_expected_events", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N x N weight-stationary PEs).
REQ-002 Parameter CW, default 8: width of the row-count and index counters.
REQ-003 Parameter L, default 3*N-1: result latency in enabled cycles (PE 2-cycle latency plus N-1 skew).
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 start  input  1: request one tile operation; sampled in IDLE only.
REQ-007 num_rows  input  CW: activation vector count M, latched when start is accepted.
REQ-008 abort  input  1: synchronous cancel of the current operation.
REQ-009 act_avail  input  1: activation feeder holds a vector for the current act_row.
REQ-010 weight_load  output  1: drives the PE array weight_load.
REQ-011 w_row  output  clog2(N): weight row being loaded.
REQ-012 clear  output  1: drives the PE array synchronous clear.
REQ-013 en  output  1: array clock-enable; 0 freezes PE pipeline and result tracking.
REQ-014 act_rd  output  1: pops one activation vector from the feeder.
REQ-015 act_row  output  CW: index of the vector popped by act_rd.
REQ-016 res_valid  output  1: psum_out row at array bottom is valid this cycle.
REQ-017 res_row  output  CW: index of the result row flagged by res_valid.
REQ-018 busy  output  1: high in every state except IDLE.
REQ-019 done  output  1: single-cycle completion pulse.

Function
REQ-020 FSM states: IDLE, LOAD_W, CLEAR, STREAM, DRAIN, DONE; encoding is free.
REQ-021 IDLE: start=1 latches num_rows and moves to LOAD_W next cycle; start in any other state is ignored.
REQ-022 LOAD_W: exactly N cycles; weight_load=1; w_row counts 0..N-1; then CLEAR.
REQ-023 CLEAR: exactly 1 cycle; clear=1; then STREAM if M>0, else DONE (STREAM and DRAIN skipped).
REQ-024 STREAM: act_rd = act_avail, en = act_avail; act_row starts at 0 and increments per act_rd; after the M-th act_rd, move to DRAIN.
REQ-025 STREAM stall: act_avail=0 gives act_rd=0 and en=0; counters and the result delay line hold.
REQ-026 DRAIN: exactly L cycles with en=1 and act_rd=0; then DONE.
REQ-027 DONE: done=1 for one cycle, busy=1; then IDLE.
REQ-028 en=1 in LOAD_W, CLEAR, DRAIN and DONE; en=0 in IDLE.
REQ-029 Result tracking: an L-deep 1-bit delay line shifts act_rd only on en=1 cycles.
REQ-030 res_valid asserts exactly L enabled cycles after its act_rd; exactly M res_valid pulses per operation; the last falls in the final DRAIN cycle.
REQ-031 res_row: 0 at operation start; increments after each res_valid; equals the matching act_row.
REQ-032 abort (any non-IDLE state): next cycle is IDLE; delay line and counters cleared; done not pulsed; abort in IDLE has no effect.
REQ-033 abort and start in the same IDLE cycle: start wins.
REQ-034 M = 2^CW-1 (max) completes without wrap; act_row and res_row never exceed M-1.
REQ-035 Outputs are registered or decoded from registered state only; no combinational path from start to any output.

Reset
REQ-036 rst_n=0 forces IDLE immediately; weight_load, clear, en, act_rd, res_valid, busy and done are 0; w_row, act_row and res_row are 0; delay line cleared.
REQ-037 rst_n asserted mid-operation drops the operation with no done pulse; the first start after rst_n deasserts is accepted normally.

Verification
REQ-038 N=4, M=3, act_avail=1, start at cycle 0 -> weight_load cycles 1-4 (w_row 0..3); clear cycle 5; act_rd cycles 6-8; res_valid cycles 17-19 (res_row 0,1,2); done cycle 20.
REQ-039 Same run, act_avail=0 in cycle 7 -> act_rd cycles 6,8,9; en=0 in cycle 7; res_valid cycles 18-20; done cycle 21.
REQ-040 M=0 -> weight_load cycles 1-4, clear cycle 5, done cycle 6, no act_rd or res_valid.
REQ-041 abort in cycle 12 of the REQ-038 run -> IDLE in cycle 13, no further res_valid, no done; a new start in cycle 15 runs to completion from w_row 0.
REQ-042 rst_n low during DRAIN -> all outputs 0 immediately; start pulsed during busy is ignored; start pulsed together with abort in IDLE is accepted.
REQ-043 M=255 with random act_avail -> 255 act_rd, 255 res_valid with res_row 0..254 in order, one done.
